// File: rtl/kypd_pkg.sv
// Shared types and the keypad map for the 4x4 keypad scanner.
package kypd_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } frame_res_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } kypd_state_e;

  // Indexed [row][column]; row 0 is the top row of the keypad.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

endpackage

// File: rtl/kypd_if.sv
// Key report bus: accepted-key events and the entry register, plus the entry clear.
interface kypd_if;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] entry;

  modport master (input clear, output key_valid, key_code, key_down, entry);
  modport slave  (output clear, input key_valid, key_code, key_down, entry);
endinterface

// File: rtl/kypd_debounce.sv
// Frame-level debounce: counts consecutive identical frame results and turns
// stable SINGLE / NONE results into one-shot accept / release events.
module kypd_debounce
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_stb,
  input  frame_res_e res,
  input  logic [3:0] code,
  output logic       key_accept,
  output logic       key_release
);

  localparam int             CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_SCANS);

  frame_res_e    prev_res_r;
  logic [3:0]    prev_code_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          same_s;
  logic          stable_s;
  kypd_state_e   state_r;
  kypd_state_e   state_next_s;

  // Stable-count update; the code is part of the result so two different keys never match.
  always_comb begin
    same_s     = (res == prev_res_r) && (code == prev_code_r);
    cnt_next_s = CW'(1);
    if (!same_s) begin
      cnt_next_s = CW'(1);
    end else if (cnt_r >= CNT_MAX) begin
      cnt_next_s = CNT_MAX;
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
    stable_s = (cnt_next_s == CNT_MAX);
  end

  // Previous-result register and stable counter, advanced once per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_res_r  <= NONE;
      prev_code_r <= 4'h0;
      cnt_r       <= '0;
    end else if (frame_stb) begin
      prev_res_r  <= res;
      prev_code_r <= code;
      cnt_r       <= cnt_next_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and events; MULTI and a second SINGLE while held never transition.
  always_comb begin
    state_next_s = state_r;
    key_accept   = 1'b0;
    key_release  = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_stb && (res == SINGLE) && stable_s) begin
          state_next_s = PRESSED;
          key_accept   = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      PRESSED: begin
        if (frame_stb && (res == NONE) && stable_s) begin
          state_next_s = IDLE;
          key_release  = 1'b1;
        end else begin
          state_next_s = PRESSED;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/kypd_scanner.sv
// 4x4 keypad scanner: column drive, row sampling, frame classification,
// debounced key reporting and a 32-bit shift-in entry register.
module kypd_scanner
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] kypd_row,
  output logic [3:0] kypd_col,
  kypd_if.master     key
);

  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]      row_meta_r;
  logic [3:0]      row_sync_r;
  logic [DW-1:0]   dwell_r;
  logic [1:0]      col_r;
  logic [3:0]      col_drv_r;
  logic [3:0][3:0] samp_r;
  logic [3:0][3:0] frame_s;
  logic            dwell_last_s;
  logic            frame_stb_s;
  logic [1:0]      n_low_s;
  logic [3:0]      hit_code_s;
  frame_res_e      res_s;
  logic [3:0]      res_code_s;
  logic            accept_s;
  logic            release_s;
  logic            key_valid_r;
  logic [3:0]      key_code_r;
  logic            key_down_r;
  logic [31:0]     entry_r;

  // Two-flop synchronizer for the asynchronous row lines (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= kypd_row;
      row_sync_r <= row_meta_r;
    end
  end

  assign dwell_last_s = (dwell_r == DWELL_LAST);
  assign frame_stb_s  = dwell_last_s && (col_r == 2'd3);

  // Dwell and column counters; the drive pattern is registered alongside the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_r   <= '0;
      col_r     <= 2'd0;
      col_drv_r <= 4'b1110;
    end else if (dwell_last_s) begin
      dwell_r   <= '0;
      col_r     <= col_r + 2'd1;
      col_drv_r <= ~(4'b0001 << (col_r + 2'd1));
    end else begin
      dwell_r   <= dwell_r + DW'(1);
    end
  end

  // Capture the settled rows at the end of each column's dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_r <= {4{4'hF}};
    end else if (dwell_last_s) begin
      samp_r[col_r] <= row_sync_r;
    end
  end

  // Column 3 is still being sampled at frame end, so its rows come straight from the synchronizer.
  always_comb begin
    frame_s    = samp_r;
    frame_s[3] = row_sync_r;
    n_low_s    = 2'd0;
    hit_code_s = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        hit_code_s = !frame_s[c][r] ? KEYMAP[r][c] : hit_code_s;
        n_low_s    = (!frame_s[c][r] && (n_low_s != 2'd2)) ? n_low_s + 2'd1 : n_low_s;
      end
    end
    case (n_low_s)
      2'd0:    res_s = NONE;
      2'd1:    res_s = SINGLE;
      default: res_s = MULTI;
    endcase
    res_code_s = (n_low_s == 2'd1) ? hit_code_s : 4'h0;
  end

  kypd_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_stb   (frame_stb_s),
    .res         (res_s),
    .code        (res_code_s),
    .key_accept  (accept_s),
    .key_release (release_s)
  );

  // Key report and entry registers; an acceptance wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      key_down_r  <= 1'b0;
      entry_r     <= 32'h0;
    end else begin
      key_valid_r <= accept_s;
      if (accept_s) begin
        key_code_r <= res_code_s;
        key_down_r <= 1'b1;
      end else if (release_s) begin
        key_down_r <= 1'b0;
      end
      if (accept_s) begin
        entry_r <= key.clear ? {28'h0, res_code_s} : {entry_r[27:0], res_code_s};
      end else if (key.clear) begin
        entry_r <= 32'h0;
      end
    end
  end

  assign kypd_col      = col_drv_r;
  assign key.key_valid = key_valid_r;
  assign key.key_code  = key_code_r;
  assign key.key_down  = key_down_r;
  assign key.entry     = entry_r;

endmodule

// File: tb/tb_kypd_scanner.sv
// Scoreboard bench for kypd_scanner: a keypad model drives the rows from the
// column drive, expected key events are queued and checked by a monitor.
module tb_kypd_scanner;

  localparam int SD      = 8;
  localparam int DB      = 3;
  localparam int FRAME   = 4 * SD;
  localparam int LAT_MIN = (DB - 1) * FRAME + 3;
  localparam int LAT_MAX = (DB + 1) * FRAME + 3;

  typedef struct {
    logic [3:0]  code;
    int unsigned t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  kypd_row;
  logic [3:0]  kypd_col;
  logic [15:0] pressed = 16'h0;
  logic        clr_edge = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;
  exp_t        expq[$];

  // Keypad legend, index row*4+column.
  logic [3:0] tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                           4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  kypd_if bus();

  kypd_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .kypd_row (kypd_row),
    .kypd_col (kypd_col),
    .key      (bus)
  );

  always #5 clk = ~clk;

  // A pressed switch pulls its row low only while its column is driven low.
  always_comb begin
    kypd_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kypd_col[c]) kypd_row[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  always @(posedge clk) clr_edge <= bus.clear;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic check_range(input string nm, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      failures++;
      $display("FAIL %s: got %0d required %0d..%0d", nm, v, lo, hi);
    end
  endtask

  function automatic int idx_of(input logic [3:0] code);
    for (int i = 0; i < 16; i++) if (tbl[i] == code) return i;
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [3:0] code);
    exp_t e;
    e.code = code;
    e.t    = cyc;
    expq.push_back(e);
  endtask

  task automatic wait_drained(input string nm, input int budget);
    int k = 0;
    while (expq.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL %s: got %0d pending presses required 0", nm, expq.size());
      expq.delete();
    end
  endtask

  task automatic release_wait(input string nm);
    int unsigned t0;
    int k = 0;
    pressed = 16'h0;
    t0 = cyc;
    tick(LAT_MIN - 7);
    check({nm, "_down_held"}, {31'h0, bus.key_down}, 32'h1);
    while (bus.key_down && k < 2 * FRAME) begin
      tick(1);
      k++;
    end
    check_range({nm, "_release_latency"}, bus.key_down ? 9999 : int'(cyc - t0), LAT_MIN, LAT_MAX);
  endtask

  task automatic type_key(input logic [3:0] code, input int extra);
    push_exp(code);
    pressed[idx_of(code)] = 1'b1;
    tick(LAT_MAX + extra);
    wait_drained("press", 40);
    release_wait("key");
  endtask

  // Monitor: pops an expectation on every pulse and tracks code and entry.
  initial begin : monitor
    logic [31:0] ent_model;
    logic [3:0]  code_model;
    exp_t        e;
    ent_model  = 32'h0;
    code_model = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ent_model  = 32'h0;
        code_model = 4'h0;
      end else begin
        if (clr_edge) ent_model = 32'h0;
        if (bus.key_valid) begin
          pulses++;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_key_valid: got code %h required no pulse", bus.key_code);
          end else begin
            e = expq.pop_front();
            code_model = e.code;
            ent_model  = {ent_model[27:0], e.code};
            check_range("press_latency", int'(cyc - e.t), LAT_MIN, LAT_MAX);
            check("key_down_on_accept", {31'h0, bus.key_down}, 32'h1);
          end
        end
        check("key_code", {28'h0, bus.key_code}, {28'h0, code_model});
        check("entry", bus.entry, ent_model);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0]  one;
    logic [3:0]  code;
    int          p0;
    one = 4'b0001;
    bus.clear = 1'b0;
    tick(3);
    check("rst_col",   {28'h0, kypd_col},      32'hE);
    check("rst_valid", {31'h0, bus.key_valid}, 32'h0);
    check("rst_code",  {28'h0, bus.key_code},  32'h0);
    check("rst_down",  {31'h0, bus.key_down},  32'h0);
    check("rst_entry", bus.entry,              32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      check("scan_col", {28'h0, kypd_col}, {28'h0, ~(one << ((cyc / SD) % 4))});
      @(negedge clk);
    end
    tick(4 * FRAME);
    check("idle_no_pulse", pulses, 0);

    // Single key "8" held for 6 frames.
    push_exp(4'h8);
    pressed[idx_of(4'h8)] = 1'b1;
    tick(6 * FRAME);
    wait_drained("key8", 10);
    release_wait("key8");
    check("entry_after_8", bus.entry, 32'h00000008);

    // Multi-digit entry.
    p0 = pulses;
    foreach (tbl[i]) begin end
    begin
      logic [3:0] seq [9] = '{4'h1, 4'hA, 4'h0, 4'hF, 4'hE, 4'hD, 4'h3, 4'h4, 4'h5};
      for (int i = 0; i < 9; i++) type_key(seq[i], int'($urandom_range(0, 31)));
    end
    check("entry_seq", bus.entry, 32'hA0FED345);
    check("seq_pulses", pulses - p0, 9);

    // Bounce on key "1": alternating frames never become stable.
    for (int i = 0; i < 4; i++) begin
      pressed[0] = ~pressed[0];
      tick(FRAME);
    end
    push_exp(4'h1);
    pressed[0] = 1'b1;
    tick(LAT_MAX);
    wait_drained("bounce", 40);
    release_wait("bounce");

    // Two keys at once, then only "2".
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    tick(10 * FRAME);
    check("multi_no_pulse", pulses - p0, 0);
    push_exp(4'h2);
    pressed[0] = 1'b0;
    tick(LAT_MAX);
    wait_drained("multi_then_2", 40);
    release_wait("multi");

    // Random keys with random timing.
    for (int i = 0; i < 6; i++) begin
      code = 4'($urandom_range(0, 15));
      type_key(code, int'($urandom_range(0, 40)));
    end

    // CLEAR pulsed on every frame-end edge while "5" debounces.
    push_exp(4'h5);
    pressed[idx_of(4'h5)] = 1'b1;
    for (int k = 0; k < LAT_MAX + 40 && expq.size() != 0; k++) begin
      bus.clear = ((cyc % FRAME) == FRAME - 1);
      tick(1);
    end
    bus.clear = 1'b0;
    wait_drained("clear5", 4);
    tick(2);
    check("entry_clear5", bus.entry, 32'h00000005);
    release_wait("clear5");

    // Reset while a key is held down.
    push_exp(4'h7);
    pressed[idx_of(4'h7)] = 1'b1;
    tick(LAT_MAX);
    wait_drained("key7", 40);
    check("down_before_rst", {31'h0, bus.key_down}, 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_col",   {28'h0, kypd_col},      32'hE);
    check("midrst_valid", {31'h0, bus.key_valid}, 32'h0);
    check("midrst_code",  {28'h0, bus.key_code},  32'h0);
    check("midrst_down",  {31'h0, bus.key_down},  32'h0);
    check("midrst_entry", bus.entry,              32'h0);
    pressed = 16'h0;
    tick(4);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    tick(6 * FRAME);
    check("post_rst_no_pulse", pulses - p0, 0);
    check("post_rst_down", {31'h0, bus.key_down}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
